// File: rtl/mac_pipe_array_if.sv
// Operand and result handshake bundle for mac_pipe_array.
// The master drives operand sets and accepts results; the slave is the MAC array.
interface mac_pipe_array_if #(
  parameter int LANES = 4,
  parameter int OP_W  = 32,
  parameter int ACC_W = 64
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   signed_mode;
  logic [LANES*OP_W-1:0]  op_a;
  logic [LANES*OP_W-1:0]  op_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] acc_out;

  modport master (
    output in_valid, signed_mode, op_a, op_b, out_ready,
    input  in_ready, out_valid, acc_out
  );

  modport slave (
    input  in_valid, signed_mode, op_a, op_b, out_ready,
    output in_ready, out_valid, acc_out
  );
endinterface

// File: rtl/mac_pipe_array.sv
// mac_pipe_array: LANES independent multiply-accumulate lanes computing
// TERMS-long dot products. Stage 1 registers the extended product, stage 2
// accumulates and emits the finished sum. A set accepted on edge E produces
// its result on edge E+1, i.e. visible two cycles after it was presented.
// Optional feature: define MAC_SATURATE_EN to clamp each lane's accumulation
// (signed or unsigned range per signed_mode) and report it on sat_flag;
// without it accumulation wraps and sat_flag is 0.
module mac_pipe_array #(
  parameter int LANES = 4,
  parameter int OP_W  = 32,
  parameter int ACC_W = 64,
  parameter int TERMS = 8,
  localparam int CNT_W = $clog2(TERMS + 1)
) (
  input  logic             Clock_50,
  input  logic             Resetn,
  input  logic             clear_n,
  mac_pipe_array_if.slave  bus,
  output logic [CNT_W-1:0] term_count,
  output logic [LANES-1:0] sat_flag
);

  localparam logic [CNT_W-1:0] TERMS_C = CNT_W'(TERMS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] term_count_reg;
  logic [CNT_W-1:0] count_next;
  logic             s1_valid_reg;
  logic             s1_first_reg;
  logic             s1_last_reg;
  logic             out_valid_reg;
  logic             accept;
  logic             stall;
  logic             s2_go;
  logic             result_load;

  // A new set may enter whenever the result slot is empty or being drained.
  assign bus.in_ready = clear_n & (~out_valid_reg | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign count_next   = (term_count_reg == TERMS_C) ? ONE_C : term_count_reg + ONE_C;

  // A last-term product must not overwrite a result still waiting for the
  // consumer, so stage 2 (and stage 1 behind it) holds in that case.
  assign stall       = s1_valid_reg & s1_last_reg & out_valid_reg & ~bus.out_ready;
  assign s2_go       = s1_valid_reg & ~stall & clear_n;
  assign result_load = s2_go & s1_last_reg;

  assign term_count    = term_count_reg;
  assign bus.out_valid = out_valid_reg;

`ifdef MAC_SATURATE_EN
  logic s1_signed_reg;

  // Signedness travels with the product so the clamp range matches the term.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn)     s1_signed_reg <= 1'b0;
    else if (accept) s1_signed_reg <= bus.signed_mode;
  end
`endif

  // Term counting, stage-1 control bits and the result-valid flag.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      term_count_reg <= '0;
      s1_valid_reg   <= 1'b0;
      s1_first_reg   <= 1'b0;
      s1_last_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      if (!clear_n) begin
        term_count_reg <= '0;
        s1_valid_reg   <= 1'b0;
      end else if (accept) begin
        term_count_reg <= count_next;
        s1_valid_reg   <= 1'b1;
        s1_first_reg   <= (count_next == ONE_C);
        s1_last_reg    <= (count_next == TERMS_C);
      end else if (!stall) begin
        s1_valid_reg   <= 1'b0;
      end
      // The result slot follows its own handshake; a flush does not touch it.
      if (result_load)        out_valid_reg <= 1'b1;
      else if (bus.out_ready) out_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [2*OP_W-1:0] prod_u;
    logic [2*OP_W-1:0] prod_s;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  s1_prod_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  sum_final;
    logic [ACC_W-1:0]  lane_out_reg;

    assign a = bus.op_a[gi*OP_W +: OP_W];
    assign b = bus.op_b[gi*OP_W +: OP_W];

    // Low 2*OP_W bits of the product of sign-extended operands is the exact signed product.
    assign prod_u   = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
    assign prod_s   = {{OP_W{a[OP_W-1]}}, a} * {{OP_W{b[OP_W-1]}}, b};
    assign prod_ext = bus.signed_mode ? ACC_W'($signed(prod_s)) : ACC_W'(prod_u);

    // A first term starts from zero, so a new dot product needs no bubble.
    assign acc_base = s1_first_reg ? '0 : acc_reg;

`ifdef MAC_SATURATE_EN
    logic [ACC_W:0] wide_sum;
    logic           sat_hit;
    logic           sat_reg;

    assign wide_sum = {1'b0, acc_base} + {1'b0, s1_prod_reg};

    // Clamp: signed overflow when like-signed addends flip the sign, unsigned on carry out.
    always_comb begin
      sat_hit   = 1'b0;
      sum_final = wide_sum[ACC_W-1:0];
      if (s1_signed_reg) begin
        if ((acc_base[ACC_W-1] == s1_prod_reg[ACC_W-1]) &&
            (wide_sum[ACC_W-1] != acc_base[ACC_W-1])) begin
          sat_hit   = 1'b1;
          sum_final = {acc_base[ACC_W-1], {(ACC_W-1){~acc_base[ACC_W-1]}}};
        end
      end else if (wide_sum[ACC_W]) begin
        sat_hit   = 1'b1;
        sum_final = '1;
      end
    end

    // Saturation flag restarts with each dot product's first term and is sticky after.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn)    sat_reg <= 1'b0;
      else if (s2_go) sat_reg <= s1_first_reg ? sat_hit : (sat_reg | sat_hit);
    end

    assign sat_flag[gi] = sat_reg;
`else
    assign sum_final    = acc_base + s1_prod_reg;
    assign sat_flag[gi] = 1'b0;
`endif

    // Stage-1 product register and stage-2 accumulator / result register.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
        s1_prod_reg  <= '0;
        acc_reg      <= '0;
        lane_out_reg <= '0;
      end else begin
        if (accept) s1_prod_reg <= prod_ext;
        if (!clear_n) begin
          acc_reg <= '0;
        end else if (s2_go) begin
          acc_reg <= s1_last_reg ? '0 : sum_final;
          if (s1_last_reg) lane_out_reg <= sum_final;
        end
      end
    end

    assign bus.acc_out[gi*ACC_W +: ACC_W] = lane_out_reg;
  end

endmodule

// File: doc/mac_pipe_array.md
MAC_PIPE_ARRAY -- requirements
Module: mac_pipe_array

Interface
REQ-001 The block SHALL have parameter LANES, default 4, number of independent MAC lanes.
REQ-002 The block SHALL have parameter OP_W, default 32, operand width per lane.
REQ-003 The block SHALL have parameter ACC_W, default 64, accumulator width per lane, with ACC_W >= 2*OP_W.
REQ-004 The block SHALL have parameter TERMS, default 8, products per dot product, with TERMS >= 1.
REQ-005 The block SHALL have port Clock_50, input, 1 bit, 50 MHz clock, rising-edge active.
REQ-006 The block SHALL have port Resetn, input, 1 bit, reset: asynchronous, active-low.
REQ-007 The block SHALL have port clear_n, input, 1 bit, synchronous active-low flush.
REQ-008 The block SHALL have port signed_mode, input, 1 bit, 1 = two's-complement operands, 0 = unsigned; sampled with each accepted operand set.
REQ-009 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), the operand handshake.
REQ-010 The block SHALL have ports op_a and op_b, inputs, LANES*OP_W bits each; lane i occupies bits [i*OP_W +: OP_W].
REQ-011 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), the result handshake.
REQ-012 The block SHALL have port acc_out, output, LANES*ACC_W bits, finished dot products with lane i at [i*ACC_W +: ACC_W].
REQ-013 The block SHALL have port term_count, output, clog2(TERMS+1) bits, number of terms accepted into the current dot product.
REQ-014 The block SHALL have port sat_flag, output, LANES bits, per-lane saturation indicator (see Configuration).

Function
REQ-015 An operand set SHALL be accepted on a rising edge where in_valid and in_ready are both 1 and clear_n is 1.
REQ-016 in_ready SHALL equal clear_n AND (NOT out_valid OR out_ready), combinationally.
REQ-017 Stage 1 SHALL register the per-lane product, OP_W x OP_W -> 2*OP_W bits, extended to ACC_W (sign-extended when signed_mode = 1, zero-extended when 0), together with a valid bit and a last-term bit.
REQ-018 Stage 2 SHALL add a valid stage-1 product to the lane accumulator once per cycle; a first-term product SHALL load the accumulator directly (no bubble between dot products).
REQ-019 When the last-term product is summed, the sum SHALL be written to acc_out, out_valid SHALL be set, and the accumulator SHALL be zeroed, all on the same edge.
REQ-020 Latency SHALL be 2 cycles: out_valid rises on the second rising edge after acceptance of the TERMS-th operand set.
REQ-021 term_count SHALL increment on each acceptance, wrap from TERMS to 1 when a new set is accepted after the last term, and read 0 after reset or clear.
REQ-022 out_valid SHALL clear on the edge where out_valid and out_ready are both 1, unless a new result loads on that same edge, in which case it SHALL stay 1 with the new data.
REQ-023 acc_out SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-024 Without MAC_SATURATE_EN, accumulation SHALL wrap modulo 2^ACC_W.
REQ-025 When TERMS = 1, every accepted set SHALL produce one result 2 cycles later.

Reset
REQ-026 On Resetn = 0, all of the following SHALL be 0 immediately, independent of the clock: accumulators, stage-1 registers, term_count, acc_out, out_valid, sat_flag. in_ready SHALL follow REQ-016.
REQ-027 clear_n = 0 at a rising edge SHALL zero the accumulators, term_count and stage-1 valid, discard any in-flight partial sum, and leave acc_out and out_valid unchanged; clear_n takes priority over a simultaneous in_valid.
REQ-028 Resetn deasserted mid-dot-product SHALL restart counting at term 1 with no residual sum.

Configuration
REQ-029 With macro MAC_SATURATE_EN defined, each lane SHALL clamp its accumulation to the maximum or minimum representable ACC_W value (signed or unsigned range per signed_mode) and set its sat_flag bit; sat_flag SHALL clear when the next dot product starts.
REQ-030 With MAC_SATURATE_EN undefined, the block SHALL wrap per REQ-024, and sat_flag SHALL be tied to 0.

Verification
REQ-031 LANES=4, TERMS=8, unsigned, lane i operands a=i+1, b=2, 8 back-to-back sets -> acc_out lanes = 16, 32, 48, 64; out_valid rises exactly 2 cycles after the 8th acceptance.
REQ-032 Signed, a=-3, b=5 for 8 terms -> lane result = -120 (0xFFFF_FFFF_FFFF_FF88 at ACC_W=64); the same data unsigned -> the zero-extended product sum.
REQ-033 Hold out_ready=0 with one result pending, keep in_valid=1 -> in_ready falls to 0, acc_out stable, no set accepted; releasing out_ready resumes with no lost or duplicated term.
REQ-034 Pulse clear_n=0 after 3 accepted terms -> term_count=0; the next 8 terms yield only their own sum.
REQ-035 Two dot products back-to-back with out_ready=1 -> two results on consecutive result edges, with no idle input cycle.
REQ-036 With MAC_SATURATE_EN, signed, a=b=0x7FFF_FFFF, 8 terms -> acc_out = 0x7FFF_FFFF_FFFF_FFFF and sat_flag=1 for the lane; without the macro -> wrapped value and sat_flag=0.
